// File: rtl/mem_port_arbiter_if.sv
// Two-requester memory port bundle: requester command/response pairs plus the shared memory side.
// The slave modport is the arbiter's view; master is the requesters/memory view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic              req0, req1;
   logic              we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic [STRB_W-1:0] wstrb0, wstrb1;
   logic              gnt0, gnt1;
   logic              rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata0, rdata1;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [STRB_W-1:0] mem_wstrb;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, wstrb0, wstrb1,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_rdata
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, wstrb0, wstrb1,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between two requesters.
// Optional macro ARB_STATS_EN adds saturating grant/stall counters.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]       grant_cnt0,
   output logic [31:0]       grant_cnt1,
   output logic [31:0]       stall_cnt
`endif
);
   localparam int STRB_W = DATA_W / 8;
   localparam int LAT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   logic [0:0]        state;
   logic              owner, owner_rd, last_gnt;
   logic [LAT_W-1:0]  lat_cnt;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        rvalid_q;

   logic [1:0]                    req, we;
   logic [1:0][ADDR_W-1:0]        addr;
   logic [1:0][DATA_W-1:0]        wdata;
   logic [1:0][STRB_W-1:0]        wstrb;
   logic                          win, grant;

   assign req   = {bus.req1,   bus.req0};
   assign we    = {bus.we1,    bus.we0};
   assign addr  = {bus.addr1,  bus.addr0};
   assign wdata = {bus.wdata1, bus.wdata0};
   assign wstrb = {bus.wstrb1, bus.wstrb0};

   // On a tie the port that did not win last time goes first.
   always_comb begin
      win = 1'b0;
      if (req[0] && req[1]) win = ~last_gnt;
      else                  win = req[1];
   end

   assign grant = !reset && (state == IDLE) && (|req);

   assign bus.gnt0      = grant && !win;
   assign bus.gnt1      = grant &&  win;
   assign bus.mem_en    = grant;
   assign bus.mem_we    = grant && we[win];
   assign bus.mem_addr  = grant ? addr[win]  : '0;
   assign bus.mem_wdata = grant ? wdata[win] : '0;
   assign bus.mem_wstrb = grant ? wstrb[win] : '0;

   assign bus.rvalid0 = rvalid_q[0];
   assign bus.rvalid1 = rvalid_q[1];
   assign bus.rdata0  = rvalid_q[0] ? rdata_q : '0;
   assign bus.rdata1  = rvalid_q[1] ? rdata_q : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= 1'b0;
         owner_rd <= 1'b0;
         last_gnt <= 1'b1;
         lat_cnt  <= '0;
         rdata_q  <= '0;
         rvalid_q <= '0;
      end else begin
         rvalid_q <= '0;
         case (state)
            IDLE: begin
               if (grant) begin
                  state    <= WAIT;
                  owner    <= win;
                  owner_rd <= !we[win];
                  last_gnt <= win;
                  lat_cnt  <= LAT_INIT;
               end
            end
            default: begin
               if (lat_cnt != '0) begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end else begin
                  // Writes complete with zero data so the requester sees a clean pulse.
                  rdata_q         <= owner_rd ? bus.mem_rdata : '0;
                  rvalid_q[owner] <= 1'b1;
                  state           <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
         stall_cnt  <= '0;
      end else begin
         if (bus.gnt0 && !(&grant_cnt0))         grant_cnt0 <= grant_cnt0 + 32'd1;
         if (bus.gnt1 && !(&grant_cnt1))         grant_cnt1 <= grant_cnt1 + 32'd1;
         if ((|req) && !grant && !(&stall_cnt))  stall_cnt  <= stall_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: latency-1 and latency-3 arbiters, each with a small strobed memory model.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

`ifdef ARB_STATS_EN
   logic [31:0] gc0_a, gc1_a, sc_a, gc0_b, gc1_b, sc_b;
`endif

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a)
`ifdef ARB_STATS_EN
      , .grant_cnt0(gc0_a), .grant_cnt1(gc1_a), .stall_cnt(sc_a)
`endif
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b)
`ifdef ARB_STATS_EN
      , .grant_cnt0(gc0_b), .grant_cnt1(gc1_b), .stall_cnt(sc_b)
`endif
   );

   // Memory models: contents reload on reset, read data delayed by the port latency.
   logic [31:0] mem_a [0:15];
   logic [31:0] mem_b [0:15];
   logic [31:0] pa;
   logic [31:0] pb [0:2];

   assign bus_a.mem_rdata = pa;
   assign bus_b.mem_rdata = pb[2];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) mem_a[i] <= '0;
         mem_a[4] <= 32'hDEADBEEF;
         mem_a[5] <= 32'h0BADF00D;
         mem_a[8] <= 32'hAAAAAAAA;
         pa       <= '0;
      end else if (bus_a.mem_en) begin
         pa <= mem_a[bus_a.mem_addr[5:2]];
         if (bus_a.mem_we)
            for (int i = 0; i < 4; i++)
               if (bus_a.mem_wstrb[i]) mem_a[bus_a.mem_addr[5:2]][8*i +: 8] <= bus_a.mem_wdata[8*i +: 8];
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         for (int j = 0; j < 16; j++) mem_b[j] <= '0;
         mem_b[4] <= 32'hCAFEF00D;
         mem_b[5] <= 32'h11112222;
         pb[0] <= '0;
         pb[1] <= '0;
         pb[2] <= '0;
      end else begin
         pb[0] <= bus_b.mem_en ? mem_b[bus_b.mem_addr[5:2]] : 32'h0;
         pb[1] <= pb[0];
         pb[2] <= pb[1];
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      bus_a.req0 = 0; bus_a.req1 = 0; bus_a.we0 = 0; bus_a.we1 = 0;
      bus_a.addr0 = '0; bus_a.addr1 = '0; bus_a.wdata0 = '0; bus_a.wdata1 = '0;
      bus_a.wstrb0 = '0; bus_a.wstrb1 = '0;
      bus_b.req0 = 0; bus_b.req1 = 0; bus_b.we0 = 0; bus_b.we1 = 0;
      bus_b.addr0 = '0; bus_b.addr1 = '0; bus_b.wdata0 = '0; bus_b.wdata1 = '0;
      bus_b.wstrb0 = '0; bus_b.wstrb1 = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset: a pending request must not leak through.
      bus_a.req0 = 1; bus_a.addr0 = 32'h10;
      @(negedge clk);
      chk("rst_gnt0",   32'(bus_a.gnt0),    0);
      chk("rst_mem_en", 32'(bus_a.mem_en),  0);
      chk("rst_addr",   bus_a.mem_addr,     0);
      chk("rst_rvalid", 32'(bus_a.rvalid0), 0);

      // Single read, latency 1.
      step(); reset = 0;
      @(negedge clk);
      chk("t1_gnt0",   32'(bus_a.gnt0),   1);
      chk("t1_gnt1",   32'(bus_a.gnt1),   0);
      chk("t1_mem_en", 32'(bus_a.mem_en), 1);
      chk("t1_addr",   bus_a.mem_addr,    32'h10);
      chk("t1_we",     32'(bus_a.mem_we), 0);
      step(); bus_a.req0 = 0;
      @(negedge clk);
      chk("t1_wait_en",   32'(bus_a.mem_en), 0);
      chk("t1_wait_addr", bus_a.mem_addr,    0);
      step();
      @(negedge clk);
      chk("t1_rvalid0", 32'(bus_a.rvalid0), 1);
      chk("t1_rdata0",  bus_a.rdata0,       32'hDEADBEEF);
      chk("t1_rvalid1", 32'(bus_a.rvalid1), 0);
      chk("t1_rdata1",  bus_a.rdata1,       0);
      step();
      @(negedge clk);
      chk("t1_pulse", 32'(bus_a.rvalid0), 0);

      // Both ports held after reset: strict alternation every 2 cycles.
      step(); reset = 1;
      step(); reset = 0;
      bus_a.req0 = 1; bus_a.addr0 = 32'h10;
      bus_a.req1 = 1; bus_a.addr1 = 32'h14;
      for (int k = 0; k <= 8; k++) begin
         if (k != 0) step();
         @(negedge clk);
         chk($sformatf("t2_gnt0_%0d", k), 32'(bus_a.gnt0), ((k % 4) == 0) ? 1 : 0);
         chk($sformatf("t2_gnt1_%0d", k), 32'(bus_a.gnt1), ((k % 4) == 2) ? 1 : 0);
         if (k == 2) chk("t2_rdata0", bus_a.rdata0, 32'hDEADBEEF);
         if (k == 4) chk("t2_rdata1", bus_a.rdata1, 32'h0BADF00D);
      end
      step(); bus_a.req0 = 0; bus_a.req1 = 0;
      @(negedge clk);
`ifdef ARB_STATS_EN
      chk("st_gcnt0", gc0_a, 3);
      chk("st_gcnt1", gc1_a, 2);
      chk("st_stall", sc_a,  4);
`endif

      // Partial-strobe write from port 1, then read-back from port 0.
      step();
      bus_a.req1 = 1; bus_a.we1 = 1; bus_a.addr1 = 32'h20;
      bus_a.wdata1 = 32'h12345678; bus_a.wstrb1 = 4'b0011;
      @(negedge clk);
      chk("t3_gnt1",  32'(bus_a.gnt1),   1);
      chk("t3_we",    32'(bus_a.mem_we), 1);
      chk("t3_wstrb", 32'(bus_a.mem_wstrb), 32'h3);
      chk("t3_wdata", bus_a.mem_wdata,   32'h12345678);
      chk("t3_addr",  bus_a.mem_addr,    32'h20);
      step(); bus_a.req1 = 0; bus_a.we1 = 0; bus_a.wdata1 = '0; bus_a.wstrb1 = '0;
      @(negedge clk);
      chk("t3_idle_wstrb", 32'(bus_a.mem_wstrb), 0);
      chk("t3_idle_wdata", bus_a.mem_wdata,       0);
      step(); bus_a.req0 = 1; bus_a.we0 = 0; bus_a.addr0 = 32'h20;
      @(negedge clk);
      chk("t3_rvalid1", 32'(bus_a.rvalid1), 1);
      chk("t3_rdata1",  bus_a.rdata1,       0);
      chk("t3_gnt0_bb", 32'(bus_a.gnt0),    1);
      step(); bus_a.req0 = 0;
      step();
      @(negedge clk);
      chk("t3_rb_valid", 32'(bus_a.rvalid0), 1);
      chk("t3_rb_data",  bus_a.rdata0,       32'hAAAA5678);

      // Latency 3: late request waits for the in-flight read.
      step(); bus_b.req0 = 1; bus_b.addr0 = 32'h10;
      @(negedge clk);
      chk("t4_gnt0", 32'(bus_b.gnt0), 1);
      step(); bus_b.req0 = 0; bus_b.req1 = 1; bus_b.addr1 = 32'h14;
      for (int k = 1; k <= 3; k++) begin
         if (k != 1) step();
         @(negedge clk);
         chk($sformatf("t4_nogrant_%0d", k), 32'(bus_b.gnt1), 0);
         chk($sformatf("t4_nrv_%0d", k), 32'(bus_b.rvalid0), 0);
      end
      step();
      @(negedge clk);
      chk("t4_rvalid0", 32'(bus_b.rvalid0), 1);
      chk("t4_rdata0",  bus_b.rdata0,       32'hCAFEF00D);
      chk("t4_gnt1",    32'(bus_b.gnt1),    1);
      step(); bus_b.req1 = 0;
      repeat (3) step();
      @(negedge clk);
      chk("t4_rvalid1", 32'(bus_b.rvalid1), 1);
      chk("t4_rdata1",  bus_b.rdata1,       32'h11112222);

      // Reset while waiting drops the transaction.
      step(); bus_a.req0 = 1; bus_a.addr0 = 32'h10;
      @(negedge clk);
      chk("t5_gnt0", 32'(bus_a.gnt0), 1);
      step(); bus_a.req0 = 0; reset = 1;
      @(negedge clk);
      chk("t5_rst_en",  32'(bus_a.mem_en), 0);
      chk("t5_rst_gnt", 32'(bus_a.gnt0),   0);
      step(); reset = 0; bus_a.req0 = 1;
      @(negedge clk);
      chk("t5_dropped",  32'(bus_a.rvalid0), 0);
      chk("t5_regrant",  32'(bus_a.gnt0),    1);
      step(); bus_a.req0 = 0;
      @(negedge clk);
      chk("t5_dropped2", 32'(bus_a.rvalid0), 0);
      step();
      @(negedge clk);
      chk("t5_rvalid", 32'(bus_a.rvalid0), 1);
      chk("t5_rdata",  bus_a.rdata0,       32'hDEADBEEF);

      step();
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
